// File: rtl/t03_pkg.sv
// Shared types and constants for the t03 RV32I core: sequencer state
// encoding and the major opcodes decoded by t03_control.
package t03_pkg;

  // Sequencer states; the encoding is visible on the o_state debug port.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } t03_seq_state_t;

  // RV32I major opcodes, plus the all-zero opcode used as a halt marker.
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_HALT   = 7'b0000000;

endpackage

// File: rtl/t03_seq_wait_timer.sv
// Bus wait timer for the sequencer. Counts cycles spent waiting for an
// acknowledge and flags expiry on the last allowed wait cycle. A
// TIMEOUT_CYC of 0 disables expiry entirely.
module t03_seq_wait_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,     // state is changing this cycle
  input  logic en,      // waiting in FETCH/MEM without an acknowledge
  output logic expire   // this is the last wait cycle allowed
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

  logic [CW-1:0] count;

  // Wait counter: cleared on every state change, saturates at LAST.
  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (!nrst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  generate
    if (TIMEOUT_CYC == 0) begin : g_no_timeout
      assign expire = 1'b0;
    end else begin : g_timeout
      assign expire = en && (count == LAST);
    end
  endgenerate

endmodule

// File: rtl/t03_cpu_sequencer.sv
// Multi-cycle instruction sequencer for the t03 core. Steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB, holds bus requests until
// acknowledged, gates PC / IR / register-file writes, halts on an all-zero
// opcode and traps bus waits that exceed TIMEOUT_CYC.
module t03_cpu_sequencer
  import t03_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_en,
  input  logic             i_resume,
  input  logic             i_ack,
  input  logic             i_memRead,
  input  logic             i_memWrite,
  input  logic             i_regWrite,
  input  logic [6:0]       i_opcode,
  output logic             o_ifetch,
  output logic             o_instr_ld,
  output logic             o_dread,
  output logic             o_dwrite,
  output logic             o_rf_we,
  output logic             o_pc_en,
  output logic             o_halted,
  output logic             o_timeout,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_instret
);

  t03_seq_state_t   state_q;
  t03_seq_state_t   state_d;
  logic             wait_en;
  logic             wait_clr;
  logic             wait_expire;
  logic [CNT_W-1:0] instret_q;

  // Only bus-waiting states count toward the timeout; an ack stops the count.
  assign wait_en  = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !i_ack;
  assign wait_clr = (state_d != state_q);

  t03_seq_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (wait_clr),
    .en     (wait_en),
    .expire (wait_expire)
  );

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; ack beats timeout in the expiry cycle.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    state_d    = state_q;
    o_ifetch   = 1'b0;
    o_instr_ld = 1'b0;
    o_dread    = 1'b0;
    o_dwrite   = 1'b0;
    o_rf_we    = 1'b0;
    o_pc_en    = 1'b0;
    o_halted   = 1'b0;
    o_timeout  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_en) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        o_ifetch = 1'b1;
        if (i_ack) begin
          o_instr_ld = 1'b1;
          state_d    = ST_DECODE;
        end else if (wait_expire) begin
          state_d = ST_ERR;
        end
      end
      ST_DECODE: begin
        state_d = (i_opcode == OP_HALT) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        state_d = (i_memRead || i_memWrite) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        // A read takes priority if the decoder flags both directions.
        o_dread  = i_memRead;
        o_dwrite = i_memWrite && !i_memRead;
        if (i_ack) begin
          state_d = ST_WB;
        end else if (wait_expire) begin
          state_d = ST_ERR;
        end
      end
      ST_WB: begin
        o_rf_we = i_regWrite;
        o_pc_en = 1'b1;
        state_d = i_en ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        o_halted = 1'b1;
        if (i_resume) state_d = ST_IDLE;
      end
      ST_ERR: begin
        o_timeout = 1'b1;
        if (i_resume) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Retired-instruction counter: one per WB cycle, wraps naturally.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      instret_q <= '0;
    end else if (state_q == ST_WB) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign o_state   = state_q;
  assign o_instret = instret_q;

endmodule

// File: tb/tb_t03_cpu_sequencer.sv
// Scoreboard bench for t03_cpu_sequencer. Stimulus pushes expected bus /
// writeback / halt events; a negedge monitor pops and compares them as the
// DUT produces them. A second instance with TIMEOUT_CYC=4 covers timeouts.
module tb_t03_cpu_sequencer;
  import t03_pkg::*;

  logic        clk;
  logic        nrst;
  logic        i_en, i_resume, i_ack, i_memRead, i_memWrite, i_regWrite;
  logic [6:0]  i_opcode;
  logic        o_ifetch, o_instr_ld, o_dread, o_dwrite, o_rf_we, o_pc_en;
  logic        o_halted, o_timeout;
  logic [2:0]  o_state;
  logic [31:0] o_instret;

  logic        t_en, t_resume, t_ack, t_mem_read, t_mem_write, t_reg_write;
  logic [6:0]  t_op;
  logic        t_ifetch, t_instr_ld, t_dread, t_dwrite, t_rf_we, t_pc_en;
  logic        t_halted, t_timeout;
  logic [2:0]  t_state;
  logic [31:0] t_instret;

  int tests = 0;
  int fails = 0;
  int exp_instret = 0;

  typedef enum int {EV_FETCH, EV_MEM, EV_WB, EV_HALT} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    logic     rd;
    logic     wr;
    logic     we;
    int       hold;
    int       instret;
  } ev_t;
  ev_t sb[$];

  t03_cpu_sequencer dut (
    .clk(clk), .nrst(nrst), .i_en(i_en), .i_resume(i_resume), .i_ack(i_ack),
    .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_regWrite(i_regWrite),
    .i_opcode(i_opcode), .o_ifetch(o_ifetch), .o_instr_ld(o_instr_ld),
    .o_dread(o_dread), .o_dwrite(o_dwrite), .o_rf_we(o_rf_we), .o_pc_en(o_pc_en),
    .o_halted(o_halted), .o_timeout(o_timeout), .o_state(o_state),
    .o_instret(o_instret)
  );

  t03_cpu_sequencer #(.TIMEOUT_CYC(4), .CNT_W(32)) dut_to (
    .clk(clk), .nrst(nrst), .i_en(t_en), .i_resume(t_resume), .i_ack(t_ack),
    .i_memRead(t_mem_read), .i_memWrite(t_mem_write), .i_regWrite(t_reg_write),
    .i_opcode(t_op), .o_ifetch(t_ifetch), .o_instr_ld(t_instr_ld),
    .o_dread(t_dread), .o_dwrite(t_dwrite), .o_rf_we(t_rf_we), .o_pc_en(t_pc_en),
    .o_halted(t_halted), .o_timeout(t_timeout), .o_state(t_state),
    .o_instret(t_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(ev_kind_e k, logic rd, logic wr, logic we, int hold, int ir);
    ev_t e;
    e.kind = k; e.rd = rd; e.wr = wr; e.we = we; e.hold = hold; e.instret = ir;
    sb.push_back(e);
  endfunction

  task automatic take(input ev_kind_e k, output ev_t e, output bit ok);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      ok = 1'b0;
      $display("FAIL sb_%s: DUT produced an event with nothing expected", k.name());
    end else begin
      e  = sb.pop_front();
      ok = 1'b1;
      check({"sb_kind_", k.name()}, 64'(e.kind), 64'(k));
    end
  endtask

  // Monitor: count request hold cycles and match DUT events to the scoreboard.
  int f_cnt = 0;
  int m_cnt = 0;
  bit prev_halted = 1'b0;
  bit prev_to = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    if (!nrst) begin
      f_cnt = 0; m_cnt = 0; prev_halted = 1'b0; prev_to = 1'b0;
    end else begin
      if (o_ifetch) f_cnt++;
      if (o_instr_ld) begin
        take(EV_FETCH, e, ok);
        if (ok) check("fetch_hold_cycles", 64'(f_cnt), 64'(e.hold));
      end
      if (!o_ifetch) f_cnt = 0;

      if (o_dread || o_dwrite) m_cnt++;
      if ((o_dread || o_dwrite) && i_ack) begin
        take(EV_MEM, e, ok);
        if (ok) begin
          check("mem_dread", 64'(o_dread), 64'(e.rd));
          check("mem_dwrite", 64'(o_dwrite), 64'(e.wr));
          check("mem_hold_cycles", 64'(m_cnt), 64'(e.hold));
        end
      end
      if (!(o_dread || o_dwrite)) m_cnt = 0;

      if (o_pc_en) begin
        take(EV_WB, e, ok);
        if (ok) begin
          check("wb_rf_we", 64'(o_rf_we), 64'(e.we));
          check("wb_instret", 64'(o_instret), 64'(e.instret));
        end
      end

      if (o_halted && !prev_halted) begin
        take(EV_HALT, e, ok);
        if (ok) check("halt_state", 64'(o_state), 64'(ST_HALT));
      end
      if (o_timeout && !prev_to) begin
        tests++;
        fails++;
        $display("FAIL main_timeout: o_timeout rose, expected it to stay 0");
      end
      prev_halted = o_halted;
      prev_to     = o_timeout;
    end
  end

  // One instruction on the main DUT. Called at posedge+1; returns at
  // posedge+1 after the WB cycle (or after entering HALT).
  task automatic run_instr(input logic rd, input logic wr, input logic we,
                           input logic [6:0] op, input logic exp_rd,
                           input logic exp_wr, input int f_hold,
                           input int m_hold, input bit drop_en);
    int n;
    i_memRead = rd; i_memWrite = wr; i_regWrite = we; i_opcode = op;
    push(EV_FETCH, 1'b0, 1'b0, 1'b0, f_hold, 0);
    if (op == OP_HALT) begin
      push(EV_HALT, 1'b0, 1'b0, 1'b0, 0, 0);
    end else begin
      if (rd || wr) push(EV_MEM, exp_rd, exp_wr, 1'b0, m_hold, 0);
      push(EV_WB, 1'b0, 1'b0, we, 0, exp_instret);
      exp_instret++;
    end
    n = 0;
    while (!o_ifetch && n < 20) begin
      tick();
      n++;
    end
    if (!o_ifetch) begin
      check("fetch_start_timeout", 64'(o_ifetch), 64'd1);
      return;
    end
    repeat (f_hold - 1) tick();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    if (drop_en) i_en = 1'b0;
    tick();
    if (op == OP_HALT) return;
    tick();
    if (rd || wr) begin
      repeat (m_hold - 1) tick();
      i_ack = 1'b1;
      tick();
      i_ack = 1'b0;
    end
    tick();
  endtask

  initial begin
    nrst = 1'b0;
    i_en = 0; i_resume = 0; i_ack = 0; i_memRead = 0; i_memWrite = 0; i_regWrite = 0;
    i_opcode = OP_RTYPE;
    t_en = 0; t_resume = 0; t_ack = 0; t_mem_read = 0; t_mem_write = 0; t_reg_write = 0;
    t_op = OP_RTYPE;
    repeat (3) tick();
    check("rst_state", 64'(o_state), 64'(ST_IDLE));
    check("rst_outputs", 64'({o_ifetch, o_instr_ld, o_dread, o_dwrite, o_rf_we,
                              o_pc_en, o_halted, o_timeout}), 64'd0);
    check("rst_instret", 64'(o_instret), 64'd0);
    nrst = 1'b1;
    tick();

    // Three ALU instructions back to back.
    i_en = 1'b1;
    run_instr(0, 0, 1, OP_RTYPE, 0, 0, 1, 1, 0);
    run_instr(0, 0, 1, OP_RTYPE, 0, 0, 2, 1, 0);
    run_instr(0, 0, 1, OP_ITYPE, 0, 0, 2, 1, 0);
    check("instret_after_3", 64'(o_instret), 64'd3);

    // Load with a 10-cycle data wait.
    run_instr(1, 0, 1, OP_LOAD, 1, 0, 1, 10, 0);
    // Both memRead and memWrite flagged: read wins; then a plain store.
    run_instr(1, 1, 0, OP_STORE, 1, 0, 2, 3, 0);
    run_instr(0, 1, 0, OP_STORE, 0, 1, 1, 2, 0);
    // Branch with i_en dropped mid-flight: completes, then parks in IDLE.
    run_instr(0, 0, 0, OP_BRANCH, 0, 0, 1, 1, 1);
    check("idle_after_drop", 64'(o_state), 64'(ST_IDLE));
    tick();
    check("idle_stays", 64'(o_state), 64'(ST_IDLE));
    i_resume = 1'b1;
    tick();
    i_resume = 1'b0;
    check("resume_ignored_idle", 64'(o_state), 64'(ST_IDLE));
    check("instret_after_7", 64'(o_instret), 64'd7);

    // Halt opcode.
    i_en = 1'b1;
    run_instr(0, 0, 1, OP_HALT, 0, 0, 1, 1, 0);
    repeat (2) tick();
    check("halt_sticky", 64'(o_state), 64'(ST_HALT));
    check("halt_no_pc_en", 64'({o_pc_en, o_ifetch}), 64'd0);
    check("halt_instret", 64'(o_instret), 64'd7);
    i_en = 1'b0;
    i_resume = 1'b1;
    tick();
    i_resume = 1'b0;
    check("resume_to_idle", 64'(o_state), 64'(ST_IDLE));
    check("resume_halted_low", 64'(o_halted), 64'd0);

    // Asynchronous reset in the middle of a fetch.
    i_en = 1'b1;
    repeat (3) tick();
    check("pre_reset_fetch", 64'(o_state), 64'(ST_FETCH));
    #2;
    nrst = 1'b0;
    #1;
    check("async_rst_state", 64'(o_state), 64'(ST_IDLE));
    check("async_rst_outputs", 64'({o_ifetch, o_instr_ld, o_dread, o_dwrite, o_rf_we,
                                    o_pc_en, o_halted, o_timeout}), 64'd0);
    check("async_rst_instret", 64'(o_instret), 64'd0);
    tick();
    nrst = 1'b1;
    exp_instret = 0;
    run_instr(0, 0, 1, OP_LUI, 0, 0, 1, 1, 1);
    check("instret_post_reset", 64'(o_instret), 64'd1);

    // Timeout instance (TIMEOUT_CYC=4): no ack in FETCH.
    t_en = 1'b1;
    tick();
    check("to_enter_fetch", 64'(t_state), 64'(ST_FETCH));
    repeat (3) tick();
    check("to_fetch_4th_cycle", 64'({t_state, t_timeout}), 64'({ST_FETCH, 1'b0}));
    tick();
    check("to_err_state", 64'(t_state), 64'(ST_ERR));
    check("to_err_flags", 64'({t_timeout, t_ifetch}), 64'b10);
    tick();
    check("to_err_sticky", 64'(t_state), 64'(ST_ERR));
    t_en = 1'b0;
    t_resume = 1'b1;
    tick();
    t_resume = 1'b0;
    check("to_resume_idle", 64'({t_state, t_timeout}), 64'({ST_IDLE, 1'b0}));

    // Ack in the 4th wait cycle wins over the timeout.
    t_en = 1'b1;
    tick();
    repeat (3) tick();
    t_ack = 1'b1;
    #1;
    check("to_ack_instr_ld", 64'(t_instr_ld), 64'd1);
    tick();
    t_ack = 1'b0;
    check("to_ack_decode", 64'(t_state), 64'(ST_DECODE));

    // Load that never gets a data ack: MEM times out too.
    t_mem_read = 1'b1;
    tick();
    tick();
    check("to_mem_enter", 64'({t_state, t_dread}), 64'({ST_MEM, 1'b1}));
    repeat (3) tick();
    check("to_mem_4th_cycle", 64'(t_state), 64'(ST_MEM));
    tick();
    check("to_mem_err", 64'({t_state, t_dread, t_timeout}), 64'({ST_ERR, 1'b0, 1'b1}));
    check("to_no_retire", 64'(t_instret), 64'd0);
    t_en = 1'b0;
    t_resume = 1'b1;
    tick();
    t_resume = 1'b0;
    check("to_mem_resume", 64'(t_state), 64'(ST_IDLE));

    repeat (2) tick();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
